// File: rtl/softex_fp_red_sched.sv
// softex_fp_red_sched
//   Reduces a vector of any length to one scalar through a single shared
//   N_INP-wide adder tree. Input beats are issued to the tree as they arrive.
//   Partial sums come back into an N_INP-slot collector. Full or final
//   collector contents are re-issued ("drained") until one value remains.
//
// Ports
//   clk_i, rst_ni, clear_i        clock, async active-low reset, sync clear
//   start_i, len_i, busy_o        job control
//   in_valid_i/in_ready_o/in_data_i/in_strb_i      element stream in
//   tree_valid_o/tree_ready_i/tree_op_o/tree_strb_o operand beat to tree
//   tree_clear_o                  tree flush (mirrors clear_i)
//   tree_valid_i/tree_ready_o/tree_res_i/tree_strb_i partial result from tree
//   res_valid_o/res_ready_i/res_o/res_strb_o        final scalar out
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | issuing input beats / draining collector, awaiting results
// OUT   | final scalar held on res_o until res_ready_i
module softex_fp_red_sched #(
    parameter int N_INP = 8,
    parameter int WIDTH = 16,
    parameter int LEN_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    output logic                   busy_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [N_INP*WIDTH-1:0] in_data_i,
    input  logic [N_INP-1:0]       in_strb_i,
    output logic                   tree_valid_o,
    input  logic                   tree_ready_i,
    output logic [N_INP*WIDTH-1:0] tree_op_o,
    output logic [N_INP-1:0]       tree_strb_o,
    output logic                   tree_clear_o,
    input  logic                   tree_valid_i,
    output logic                   tree_ready_o,
    input  logic [WIDTH-1:0]       tree_res_i,
    input  logic                   tree_strb_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [WIDTH-1:0]       res_o,
    output logic                   res_strb_o
);
    localparam int IDX_W = $clog2(N_INP);
    localparam int CNT_W = $clog2(N_INP + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OUT = 2'd2} state_t;

    state_t                      r_state, w_state_nxt;
    logic [LEN_W-1:0]            r_beats_left;
    logic [IDX_W-1:0]            r_tail;
    logic [CNT_W-1:0]            r_cnt, r_inflight;
    logic [N_INP-1:0][WIDTH-1:0] r_slot_val;
    logic [N_INP-1:0]            r_slot_strb;

    logic                        w_run, w_drain_req, w_in_req, w_drain_fire, w_in_fire;
    logic                        w_issue, w_arrive, w_done, w_last_beat;
    logic [OCC_W-1:0]            w_occ;
    logic [IDX_W-1:0]            w_wr_idx, w_len_tail;
    logic [LEN_W-1:0]            w_len_beats;
    logic [N_INP-1:0]            w_lane_mask, w_drain_strb;
    logic [N_INP-1:0][WIDTH-1:0] w_drain_op;

    assign w_run = (r_state == S_RUN);
    // Slots reserved for results still inside the tree count as occupied so an
    // arrival can never find the collector full.
    assign w_occ = OCC_W'(r_cnt) + OCC_W'(r_inflight);
    assign w_drain_req = w_run && ((r_cnt == CNT_W'(N_INP)) ||
                         ((r_beats_left == '0) && (r_inflight == '0) && (r_cnt > CNT_W'(1))));
    assign w_in_req = w_run && !w_drain_req && (r_beats_left != '0) && (w_occ < OCC_W'(N_INP));
    assign w_drain_fire = w_drain_req && tree_ready_i;
    assign w_in_fire = w_in_req && in_valid_i && tree_ready_i;
    assign w_issue = w_drain_fire || w_in_fire;
    assign w_arrive = w_run && tree_valid_i;
    // A drain empties the collector in the same cycle, so a concurrent arrival lands in slot 0.
    assign w_wr_idx = w_drain_fire ? '0 : r_cnt[IDX_W-1:0];
    assign w_done = w_run && (r_beats_left == '0) && (r_inflight == '0) && (r_cnt == CNT_W'(1));
    assign w_last_beat = (r_beats_left == LEN_W'(1)) && (r_tail != '0);
    assign w_len_tail = IDX_W'(32'(len_i) % N_INP);
    assign w_len_beats = LEN_W'(32'(len_i) / N_INP) + LEN_W'(w_len_tail != '0);

    always_comb begin
        w_lane_mask = '1;
        w_drain_op = '0;
        w_drain_strb = '0;
        for (int i = 0; i < N_INP; i++) begin
            if (w_last_beat && (IDX_W'(i) >= r_tail)) w_lane_mask[i] = 1'b0;
            if (CNT_W'(i) < r_cnt) begin
                w_drain_op[i] = r_slot_val[i];
                w_drain_strb[i] = r_slot_strb[i];
            end
        end
    end

    assign in_ready_o = w_in_req && tree_ready_i;
    assign tree_valid_o = w_drain_req || (w_in_req && in_valid_i);
    assign tree_op_o = w_drain_req ? w_drain_op : (w_in_req ? in_data_i : '0);
    assign tree_strb_o = w_drain_req ? w_drain_strb : (w_in_req ? (in_strb_i & w_lane_mask) : '0);
    assign tree_clear_o = clear_i;
    assign tree_ready_o = 1'b1;
    assign busy_o = (r_state != S_IDLE);
    assign res_valid_o = (r_state == S_OUT);
    assign res_o = (r_state == S_OUT) ? r_slot_val[0] : '0;
    assign res_strb_o = (r_state == S_OUT) ? r_slot_strb[0] : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? S_OUT : S_RUN;
            S_RUN:   if (w_done) w_state_nxt = S_OUT;
            S_OUT:   if (res_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beats_left <= '0;
            r_tail       <= '0;
            r_cnt        <= '0;
            r_inflight   <= '0;
            r_slot_val   <= '0;
            r_slot_strb  <= '0;
        end else if (clear_i) begin
            r_beats_left <= '0;
            r_tail       <= '0;
            r_cnt        <= '0;
            r_inflight   <= '0;
            r_slot_val   <= '0;
            r_slot_strb  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        // len_i==0 leaves slot 0 cleared, which is the zero result.
                        r_beats_left <= w_len_beats;
                        r_tail       <= w_len_tail;
                        r_cnt        <= '0;
                        r_inflight   <= '0;
                        r_slot_val   <= '0;
                        r_slot_strb  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_in_fire) r_beats_left <= r_beats_left - LEN_W'(1);
                    r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_arrive);
                    if (w_drain_fire) r_cnt <= CNT_W'(w_arrive);
                    else              r_cnt <= r_cnt + CNT_W'(w_arrive);
                    if (w_arrive) begin
                        r_slot_val[w_wr_idx]  <= tree_res_i;
                        r_slot_strb[w_wr_idx] <= tree_strb_i;
                    end
                end
                S_OUT: begin
                    if (res_ready_i) r_cnt <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_softex_fp_red_sched.sv
// Directed bench for softex_fp_red_sched with an FP16 adder-tree stub of
// configurable latency and optional random backpressure. Element values are
// small integers, so FP16 sums are exact and the golden sum is an integer sum.
module tb_softex_fp_red_sched;
    localparam int N = 8;
    localparam int W = 16;
    localparam int LW = 16;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clear_i = 1'b0;
    logic           start_i = 1'b0;
    logic [LW-1:0]  len_i = '0;
    logic           busy_o;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [N*W-1:0] in_data_i = '0;
    logic [N-1:0]   in_strb_i = '0;
    logic           tree_valid_o;
    logic           tree_ready_i = 1'b1;
    logic [N*W-1:0] tree_op_o;
    logic [N-1:0]   tree_strb_o;
    logic           tree_clear_o;
    logic           tree_valid_i = 1'b0;
    logic           tree_ready_o;
    logic [W-1:0]   tree_res_i = '0;
    logic           tree_strb_i = 1'b0;
    logic           res_valid_o;
    logic           res_ready_i = 1'b1;
    logic [W-1:0]   res_o;
    logic           res_strb_o;

    softex_fp_red_sched #(.N_INP(N), .WIDTH(W), .LEN_W(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
        .tree_valid_o(tree_valid_o), .tree_ready_i(tree_ready_i), .tree_op_o(tree_op_o),
        .tree_strb_o(tree_strb_o), .tree_clear_o(tree_clear_o),
        .tree_valid_i(tree_valid_i), .tree_ready_o(tree_ready_o), .tree_res_i(tree_res_i),
        .tree_strb_i(tree_strb_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o), .res_strb_o(res_strb_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int val; bit strb; int due;} tres_t;
    typedef struct {bit drain; logic [N-1:0] strb;} ilog_t;
    typedef struct {logic [W-1:0] val; bit strb;} exp_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit rnd_ready = 0;
    int lat_min = 3;
    int lat_max = 3;
    tres_t tq[$];
    ilog_t ilog[$];
    exp_t exp_q[$];
    int elem[$];
    logic [N-1:0] sb[$];

    // Reference occupancy model, advanced from observed handshakes.
    bit m_run = 0;
    int m_cnt = 0;
    int m_infl = 0;
    int m_bl = 0;
    int m_infl_max = 0;
    logic [N-1:0] m_sstrb = '0;

    function automatic logic [15:0] int_to_fp16(input int v);
        int e;
        int mant;
        if (v <= 0) return 16'h0000;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        mant = ((v - (1 << e)) << 10) >> e;
        return {1'b0, 5'(e + 15), 10'(mant)};
    endfunction

    function automatic int fp16_to_int(input logic [15:0] h);
        int ex;
        int m;
        if (h[14:10] == 5'd0) return 0;
        ex = int'(h[14:10]) - 15;
        m = int'({1'b1, h[9:0]});
        if (ex >= 10) return m << (ex - 10);
        if (ex < 0) return 0;
        return m >> (10 - ex);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tree stub plus protocol model, evaluated 1 time unit after each falling edge.
    always @(negedge clk_i) begin : tree_stub
        int occ;
        int s;
        int lat;
        int due;
        bit dpend;
        bit in_hs;
        bit dr_hs;
        bit arr;
        bit st;
        tres_t r;
        ilog_t li;
        cyc++;
        if (tq.size() != 0 && tq[0].due <= cyc) begin
            r = tq.pop_front();
            tree_valid_i = 1'b1;
            tree_res_i = int_to_fp16(r.val);
            tree_strb_i = r.strb;
        end else begin
            tree_valid_i = 1'b0;
            tree_res_i = '0;
            tree_strb_i = 1'b0;
        end
        tree_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (tree_clear_o) begin
            tq.delete();
            tree_valid_i = 1'b0;
            m_cnt = 0;
            m_infl = 0;
        end else begin
            in_hs = in_valid_i && in_ready_o;
            dr_hs = tree_valid_o && tree_ready_i && !in_hs;
            arr = tree_valid_i;
            if (m_run) begin
                occ = m_cnt + m_infl;
                dpend = (m_cnt == N) || (m_bl == 0 && m_infl == 0 && m_cnt > 1);
                chk("occupancy_bound", 64'(occ <= N), 64'(1));
                if (occ == N || dpend || m_bl == 0) chk("in_ready_blocked", in_ready_o, 0);
                if (dpend) begin
                    chk("drain_issued", tree_valid_o, 1);
                    chk("drain_strobe", tree_strb_o, m_sstrb & N'((1 << m_cnt) - 1));
                end
                if (in_hs) m_bl--;
                m_infl = m_infl + int'(in_hs || dr_hs) - int'(arr);
                if (dr_hs) m_cnt = 0;
                if (arr && m_cnt < N) begin
                    m_sstrb[m_cnt] = tree_strb_i;
                    m_cnt++;
                end
                if (m_infl > m_infl_max) m_infl_max = m_infl;
                if (in_hs || dr_hs) begin
                    li.drain = dr_hs;
                    li.strb = tree_strb_o;
                    ilog.push_back(li);
                end
                if (m_bl == 0 && m_infl == 0 && m_cnt == 1) m_run = 0;
            end
            if (tree_valid_o && tree_ready_i) begin
                s = 0;
                st = 0;
                for (int l = 0; l < N; l++) begin
                    if (tree_strb_o[l]) begin
                        s += fp16_to_int(tree_op_o[l*W +: W]);
                        st = 1;
                    end
                end
                lat = int'($urandom_range(lat_min, lat_max));
                due = cyc + lat;
                if (tq.size() != 0 && due < tq[$].due) due = tq[$].due;
                r.val = s;
                r.strb = st;
                r.due = due;
                tq.push_back(r);
            end
        end
    end

    // kind 0: 1,2,3..  kind 1: all ones  kind 2: random 0..15; zero_beat gets strobe 0
    task automatic set_elems(input int len, input int kind, input int zero_beat);
        logic [N-1:0] v;
        elem.delete();
        sb.delete();
        for (int i = 0; i < len; i++) begin
            if (kind == 0)      elem.push_back(i + 1);
            else if (kind == 1) elem.push_back(1);
            else                elem.push_back(int'($urandom_range(0, 15)));
        end
        for (int b = 0; b * N < len; b++) begin
            v = (b == zero_beat) ? N'(0) : {N{1'b1}};
            sb.push_back(v);
        end
    endtask

    task automatic start_run(input int len);
        int s;
        bit st;
        exp_t e;
        s = 0;
        st = 0;
        for (int b = 0; b * N < len; b++)
            for (int l = 0; l < N; l++)
                if (b * N + l < len && sb[b][l]) begin
                    s += elem[b * N + l];
                    st = 1;
                end
        e.val = int_to_fp16(s);
        e.strb = st;
        exp_q.push_back(e);
        ilog.delete();
        m_infl_max = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        len_i = LW'(len);
        m_cnt = 0;
        m_infl = 0;
        m_bl = (len + N - 1) / N;
        m_sstrb = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        m_run = (len != 0);
    endtask

    task automatic feed_beats(input int len);
        int t;
        int idx;
        for (int b = 0; b * N < len; b++) begin
            for (int l = 0; l < N; l++) begin
                idx = b * N + l;
                in_data_i[l*W +: W] = (idx < len) ? int_to_fp16(elem[idx]) : int_to_fp16(100);
            end
            in_strb_i = sb[b];
            in_valid_i = 1'b1;
            t = 0;
            #1;
            while (!in_ready_o && t < 500) begin
                @(negedge clk_i);
                #1;
                t++;
            end
            if (!in_ready_o) begin
                chk("feed_timeout", in_ready_o, 1);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        in_strb_i = '0;
    endtask

    task automatic wait_result();
        exp_t e;
        int t;
        t = 0;
        #1;
        while (res_valid_o !== 1'b1 && t < 3000) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        chk("result_valid", res_valid_o, 1);
        if (res_valid_o === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("res_value", res_o, e.val);
            chk("res_strb", res_strb_o, e.strb);
            if (res_ready_i) begin
                @(negedge clk_i);
                #1;
                chk("busy_after_take", busy_o, 0);
                chk("valid_after_take", res_valid_o, 0);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int seen;
        logic [W-1:0] held;
        // reset values
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_tree_valid", tree_valid_o, 0);
        chk("rst_tree_ready", tree_ready_o, 1);
        chk("rst_tree_clear", tree_clear_o, 0);
        chk("rst_res", res_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // len=8, 1..8, single issue, sum 36
        lat_min = 3; lat_max = 3;
        set_elems(8, 0, -1);
        start_run(8);
        feed_beats(8);
        wait_result();
        chk("len8_issue_count", ilog.size(), 1);
        if (ilog.size() >= 1) chk("len8_strobe", ilog[0].strb, 8'hFF);
        chk("len8_inflight_max", m_infl_max, 1);

        // len=20 ones: beats FF, FF, 0F then drain of 3 partials
        set_elems(20, 1, -1);
        start_run(20);
        feed_beats(20);
        wait_result();
        chk("len20_issue_count", ilog.size(), 4);
        if (ilog.size() == 4) begin
            chk("len20_beat2_strb", ilog[2].strb, 8'h0F);
            chk("len20_beat2_kind", ilog[2].drain, 0);
            chk("len20_drain_kind", ilog[3].drain, 1);
            chk("len20_drain_strb", ilog[3].strb, 8'h07);
        end

        // len=100 random values with random tree backpressure
        rnd_ready = 1; lat_min = 1; lat_max = 6;
        set_elems(100, 2, -1);
        start_run(100);
        feed_beats(100);
        wait_result();
        rnd_ready = 0;

        // len=0: result the cycle after start
        lat_min = 3; lat_max = 3;
        set_elems(0, 0, -1);
        start_run(0);
        #1;
        chk("len0_valid_next", res_valid_o, 1);
        wait_result();

        // masked beats: one all-zero-strobe beat, then a fully masked job
        set_elems(16, 1, 1);
        start_run(16);
        feed_beats(16);
        wait_result();
        set_elems(8, 1, 0);
        start_run(8);
        feed_beats(8);
        wait_result();

        // clear with three beats in the tree
        lat_min = 10; lat_max = 10;
        set_elems(24, 1, -1);
        start_run(24);
        feed_beats(24);
        chk("clear_infl_before", m_infl, 3);
        clear_i = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("clear_tree_clear", tree_clear_o, 1);
        @(negedge clk_i);
        clear_i = 1'b0;
        m_run = 0;
        #1;
        chk("clear_busy", busy_o, 0);
        chk("clear_in_ready", in_ready_o, 0);
        chk("clear_tree_valid", tree_valid_o, 0);
        chk("clear_tree_clear_low", tree_clear_o, 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_i);
            #1;
            if (res_valid_o || busy_o) seen++;
        end
        chk("clear_no_result", seen, 0);
        lat_min = 3; lat_max = 3;
        set_elems(8, 0, -1);
        start_run(8);
        feed_beats(8);
        wait_result();

        // result held with res_ready_i low; start pulses ignored
        res_ready_i = 1'b0;
        set_elems(8, 0, -1);
        start_run(8);
        feed_beats(8);
        wait_result();
        held = int_to_fp16(36);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            start_i = (k % 2 == 0);
            len_i = LW'(5);
            #1;
            chk("hold_valid", res_valid_o, 1);
            chk("hold_value", res_o, held);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        res_ready_i = 1'b1;
        #1;
        chk("hold_take_valid", res_valid_o, 1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            #1;
            if (res_valid_o || busy_o) seen++;
        end
        chk("hold_single_result", seen, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
